unrot_pipe: RTL
===============

Name: unrot_pipe

Overview:
- Pipelined left rotator; the inverse of the combinational right-rotate barrel shifter. Given rotated bits and amount k, it recovers the original word: out = in <<< k.
- Sits on the receive/decode side of any path that applied a right rotation by k.
- One registered stage per shift bit, log2_N stages in total. A valid/ready handshake on both sides gives full backpressure.
- Bit vectors are indexed [0:N-1]. Index 0 is the MSB. k[0] is the MSB of k.

Parameters:
N        8   word width; must be a power of 2, N >= 2
log2_N   3   log2(N); width of k and number of pipeline stages

Ports:
clk        input   1        clock, rising edge
rst_n      input   1        asynchronous active-low reset
in_valid   input   1        input word valid
in_ready   output  1        block can accept input this cycle
in_bits    input   N        rotated word, [0:N-1]
in_k       input   log2_N   rotation amount, [0:log2_N-1]
out_valid  output  1        output word valid
out_ready  input   1        consumer accepts output this cycle
out_bits   output  N        un-rotated word, [0:N-1]
out_k      output  log2_N   k that travelled with the word

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n).
  - On assertion, all stage valid bits clear immediately; data and k registers go to 0.
  - Outputs then read: out_valid=0, out_bits=0, out_k=0, in_ready=1.
  - Reset mid-operation discards every in-flight word; no partial output.
- Stages: s = 0 .. log2_N-1. Stage s holds v[s], d[s], k[s-copy].
  - Stage s shift is N >> (s+1). Stage 0 shifts by N/2.
  - If k[s]=1: d_next[i] = d_prev[(i + shift) mod N] for every i. If k[s]=0: pass-through.
  - Stage 0 takes in_bits. The last stage drives out_bits, out_k and out_valid = v[log2_N-1].
  - The complete k vector travels with the data; each stage reads only its own k bit.
- Net function: out_bits[i] = in_bits[(i + k) mod N], i.e. a left rotate by unsigned k. This exactly undoes the right rotate out[i] = in[(i - k) mod N].
- Handshake:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - adv[last] = !v[last] | out_ready.
  - adv[s] = !v[s] | adv[s+1]. This collapses bubbles: an empty stage always accepts.
  - in_ready = adv[0]. It may depend combinationally on out_ready.
  - A stage loads when adv[s] is high. v[s] takes the upstream valid, or in_valid & in_ready for stage 0.
  - A stage holding data with adv low keeps d, k and v unchanged.
- Latency: a word accepted at edge t appears with out_valid=1 after edge t+log2_N-1, i.e. log2_N register stages. With no stall, that is 3 cycles for N=8.
- Throughput: one word per cycle with out_ready held high.
- Stall behaviour:
  - out_ready=0 with all stages full forces in_ready=0; all data is held stable.
  - out_valid and out_bits must not change while out_valid=1 and out_ready=0.
- Boundary conditions:
  - k=0 gives identity.
  - k=N-1 is equivalent to a right rotate by 1.
  - Simultaneous input and output transfer on a full pipe is allowed and loses nothing.
  - in_valid with in_ready=0 is held by the producer; the block ignores it.
- No X on any output after reset, whatever the inputs.

Optional Feature:
- Macro: UNROT_CHECK_EN.
- When defined:
  - The original in_bits travels through the pipeline alongside the data.
  - Added output port out_err (1 bit, reset 0).
  - out_err = out_valid & (rotr(out_bits, out_k) != carried in_bits), where rotr is a combinational right rotate.
  - out_err is a self-check of the datapath and must stay 0 in a correct build.
- When undefined: no extra registers and no out_err port; behaviour is otherwise identical.

Test Plan:
- N=8, in_bits=8'h80, k=3'd3, out_ready=1 -> out_bits=8'h04, out_k=3, out_valid exactly 3 cycles after acceptance.
- Back-to-back with no stalls:
  - 8'hB1/k=1 -> 8'h63
  - 8'hB1/k=7 -> 8'hD8
  - 8'h5A/k=0 -> 8'h5A
  - Outputs appear on consecutive cycles, in order.
- Backpressure:
  - Stream 5 words, hold out_ready=0 for 6 cycles -> in_ready drops after 3 accepted; out_bits stays stable.
  - On release, all 5 words emerge in order with none lost or duplicated.
- Bubble collapse: send one word, stall out_ready; later words fill the empty stages, and in_ready stays 1 until all 3 stages hold valid data.
- Reset mid-stream: assert rst_n=0 asynchronously with 3 words in flight -> out_valid=0 immediately and in_ready=1 after release. The first post-reset output is the first post-reset input.
- Random round-trip: 1000 random in_bits/k with random out_ready -> rotr(out_bits,out_k) equals the original. With UNROT_CHECK_EN defined, out_err=0 throughout.

Source files
------------

// File: rtl/unrot_pipe.sv
// rtl/unrot_pipe.sv - pipelined left rotator, one registered stage per bit of k
// Define UNROT_CHECK_EN to carry the original word along and add the out_err self-check.
module unrot_pipe #(
    parameter int N      = 8,
    parameter int log2_N = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:N-1]      in_bits,
    input  logic [0:log2_N-1] in_k,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:N-1]      out_bits,
`ifdef UNROT_CHECK_EN
    output logic              out_err,
`endif
    output logic [0:log2_N-1] out_k
);
    localparam int LAST = log2_N - 1;

    // Fixed-distance left rotate used by each stage; en selects pass-through.
    function automatic logic [0:N-1] rotl_fixed(input logic [0:N-1] x, input int sh,
                                                input logic en);
        logic [0:N-1] r;
        for (int i = 0; i < N; i++) begin
            r[i] = en ? x[(i + sh) % N] : x[i];
        end
        return r;
    endfunction

    logic [log2_N-1:0] v_q, v_d;
    logic [0:N-1]      d_q [log2_N];
    logic [0:N-1]      d_d [log2_N];
    logic [0:log2_N-1] k_q [log2_N];
    logic [0:log2_N-1] k_d [log2_N];
    logic [log2_N-1:0] adv;
    logic              adv_acc;

    // A stage may load when it or any stage downstream of it is empty, or the sink takes.
    always_comb begin
        adv_acc = out_ready;
        adv     = '0;
        for (int s = LAST; s >= 0; s--) begin
            adv_acc = adv_acc | ~v_q[s];
            adv[s]  = adv_acc;
        end
    end

    assign in_ready = adv[0];

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        k_d = k_q;
        if (adv[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                d_d[0] = rotl_fixed(in_bits, N / 2, in_k[0]);
                k_d[0] = in_k;
            end
        end
        for (int s = 1; s < log2_N; s++) begin
            if (adv[s]) begin
                v_d[s] = v_q[s-1];
                // Data only moves with a valid word so idle inputs never reach the outputs.
                if (v_q[s-1]) begin
                    d_d[s] = rotl_fixed(d_q[s-1], N >> (s + 1), k_q[s-1][s]);
                    k_d[s] = k_q[s-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int s = 0; s < log2_N; s++) begin
                d_q[s] <= '0;
                k_q[s] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int s = 0; s < log2_N; s++) begin
                d_q[s] <= d_d[s];
                k_q[s] <= k_d[s];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign out_bits  = d_q[LAST];
    assign out_k     = k_q[LAST];

`ifdef UNROT_CHECK_EN
    function automatic logic [0:N-1] rotr_var(input logic [0:N-1] x,
                                              input logic [0:log2_N-1] k);
        logic [0:N-1] r;
        for (int i = 0; i < N; i++) begin
            r[i] = x[(i + N - int'(k)) % N];
        end
        return r;
    endfunction

    logic [0:N-1] orig_q [log2_N];
    logic [0:N-1] orig_d [log2_N];

    always_comb begin
        orig_d = orig_q;
        if (adv[0] && in_valid) begin
            orig_d[0] = in_bits;
        end
        for (int s = 1; s < log2_N; s++) begin
            if (adv[s] && v_q[s-1]) begin
                orig_d[s] = orig_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < log2_N; s++) begin
                orig_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < log2_N; s++) begin
                orig_q[s] <= orig_d[s];
            end
        end
    end

    // Undo the result with an independent right rotate and compare with the carried word.
    assign out_err = v_q[LAST] & (rotr_var(d_q[LAST], k_q[LAST]) != orig_q[LAST]);
`endif

endmodule
